// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback queue and its forwarding lookup.
//   WB_XLEN / WB_REG_AW / WB_DEPTH : default data width, register address
//                                    width and queue depth.
//   wbEntry_t                      : one queued result at the default widths.
//   freeSlots()                    : slots available to producers this edge.
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int WB_XLEN   = 64;
   localparam int WB_REG_AW = 5;
   localparam int WB_DEPTH  = 4;

   typedef struct packed {
      logic [WB_REG_AW-1:0] regAddr;
      logic [WB_XLEN-1:0]   data;
   } wbEntry_t;

   // The head drains on every edge where the queue is not empty, so the slot
   // it vacates is already available to a push on that same edge.
   function automatic int freeSlots(input int depth, input int count);
      return depth - count + ((count != 0) ? 1 : 0);
   endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// -----------------------------------------------------------------------------
// wb_fwd_lookup
// Combinational youngest-match search over the writeback queue entries.
// Ports:
//   queryReg   in  : register being looked up (x0 never hits)
//   entryReg   in  : destination register of every queue slot
//   entryData  in  : data of every queue slot
//   entryValid in  : per-slot occupancy
//   tailPtr    in  : next slot to be written (youngest entry is tailPtr-1)
//   hit        out : some valid entry targets queryReg
//   data       out : value of the youngest such entry, zero when no hit
// -----------------------------------------------------------------------------
module wb_fwd_lookup
   import wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int XLEN   = WB_XLEN,
   parameter int REG_AW = WB_REG_AW
) (
   input  logic [REG_AW-1:0]          queryReg,
   input  logic [REG_AW-1:0]          entryReg [DEPTH],
   input  logic [XLEN-1:0]            entryData [DEPTH],
   input  logic [DEPTH-1:0]           entryValid,
   input  logic [$clog2(DEPTH)-1:0]   tailPtr,
   output logic                       hit,
   output logic [XLEN-1:0]            data
);

   localparam int PW = $clog2(DEPTH);

   // Index k of these vectors is "age": k=0 is the youngest slot (tailPtr-1),
   // k=DEPTH-1 the oldest. Valid bits are only set inside head..tail-1, so
   // walking every age and gating with valid covers exactly the live entries.
   logic [PW-1:0]    ageIdx [DEPTH];
   logic [DEPTH-1:0] ageMatch;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_age
         // gi+1 == DEPTH truncates to 0, giving tailPtr itself, which is the
         // oldest slot when the queue is full.
         assign ageIdx[gi]   = tailPtr - PW'(gi + 1);
         assign ageMatch[gi] = entryValid[ageIdx[gi]]
                               && (entryReg[ageIdx[gi]] == queryReg)
                               && (queryReg != '0);
      end
   endgenerate

   always_comb begin
      hit  = |ageMatch;
      data = '0;
      // Walk oldest to youngest so the youngest match is the last assignment.
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (ageMatch[k]) begin
            data = entryData[ageIdx[k]];
         end
      end
   end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// In-order result queue between the ALU / load unit and the register file.
// Accepts up to two results per cycle, drains one per cycle into the single
// register file write port, and offers two forwarding lookups for decode.
// Ports:
//   Clock, Reset_n                  : clock, synchronous active-low reset
//   AluValid/AluReg/AluData/AluReady: ALU result handshake
//   MemValid/MemReg/MemData/MemReady: load result handshake
//   RegWrite/WriteReg/WriteData     : register file write port (head entry)
//   QueryReg1/QueryHit1/QueryData1  : forwarding lookup 1
//   QueryReg2/QueryHit2/QueryData2  : forwarding lookup 2
//   Count                           : current occupancy
// -----------------------------------------------------------------------------
module writeback_queue
   import wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int XLEN   = WB_XLEN,
   parameter int REG_AW = WB_REG_AW
) (
   input  logic                      Clock,
   input  logic                      Reset_n,
   input  logic                      AluValid,
   input  logic [REG_AW-1:0]         AluReg,
   input  logic [XLEN-1:0]           AluData,
   output logic                      AluReady,
   input  logic                      MemValid,
   input  logic [REG_AW-1:0]         MemReg,
   input  logic [XLEN-1:0]           MemData,
   output logic                      MemReady,
   output logic                      RegWrite,
   output logic [REG_AW-1:0]         WriteReg,
   output logic [XLEN-1:0]           WriteData,
   input  logic [REG_AW-1:0]         QueryReg1,
   input  logic [REG_AW-1:0]         QueryReg2,
   output logic                      QueryHit1,
   output logic [XLEN-1:0]           QueryData1,
   output logic                      QueryHit2,
   output logic [XLEN-1:0]           QueryData2,
   output logic [$clog2(DEPTH):0]    Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   // Queue state
   logic [PW-1:0]     headReg, headNext;
   logic [PW-1:0]     tailReg, tailNext;
   logic [CW-1:0]     countReg, countNext;
   logic [DEPTH-1:0]  validReg, validNext;
   logic [REG_AW-1:0] regMem  [DEPTH];
   logic [XLEN-1:0]   dataMem [DEPTH];

   // Per-edge control
   int            freeCnt;
   logic          memNeedsSlot;
   logic          aluNeedsSlot;
   logic          memPush;
   logic          aluPush;
   logic          doPop;
   logic [PW-1:0] memSlot;
   logic [PW-1:0] aluSlot;

   assign doPop        = (countReg != '0);
   assign freeCnt      = freeSlots(DEPTH, 32'(countReg));
   assign memNeedsSlot = (MemReg != '0);
   assign aluNeedsSlot = (AluReg != '0);

   // The load is the older result, so it gets first claim on a slot; the ALU
   // only needs two free slots when the load is actually taking one.
   assign MemReady = (freeCnt >= 1) || !memNeedsSlot;
   assign AluReady = !aluNeedsSlot
                     || (freeCnt >= 2)
                     || ((freeCnt >= 1) && !(MemValid && memNeedsSlot));

   // x0 results complete the handshake but are never enqueued.
   assign memPush = MemValid && MemReady && memNeedsSlot;
   assign aluPush = AluValid && AluReady && aluNeedsSlot;

   assign memSlot = tailReg;
   assign aluSlot = tailReg + PW'(memPush);

   always_comb begin
      headNext  = headReg + PW'(doPop);
      tailNext  = tailReg + PW'(memPush) + PW'(aluPush);
      countNext = countReg + CW'(memPush) + CW'(aluPush) - CW'(doPop);
      // Clear before set: when full, the push lands in the slot being popped.
      validNext = validReg;
      if (doPop) begin
         validNext[headReg] = 1'b0;
      end
      if (memPush) begin
         validNext[memSlot] = 1'b1;
      end
      if (aluPush) begin
         validNext[aluSlot] = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         headReg  <= '0;
         tailReg  <= '0;
         countReg <= '0;
         validReg <= '0;
      end else begin
         headReg  <= headNext;
         tailReg  <= tailNext;
         countReg <= countNext;
         validReg <= validNext;
      end
   end

   // Entry storage carries no reset; validReg alone decides what is live.
   always_ff @(posedge Clock) begin
      if (Reset_n && memPush) begin
         regMem[memSlot]  <= MemReg;
         dataMem[memSlot] <= MemData;
      end
      if (Reset_n && aluPush) begin
         regMem[aluSlot]  <= AluReg;
         dataMem[aluSlot] <= AluData;
      end
   end

   // Drain port: the register file always accepts, so the head is written
   // (and popped) on every edge where the queue holds anything.
   assign RegWrite  = doPop;
   assign WriteReg  = doPop ? regMem[headReg]  : '0;
   assign WriteData = doPop ? dataMem[headReg] : '0;
   assign Count     = countReg;

   wb_fwd_lookup #(
      .DEPTH  (DEPTH),
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) uLookup1 (
      .queryReg   (QueryReg1),
      .entryReg   (regMem),
      .entryData  (dataMem),
      .entryValid (validReg),
      .tailPtr    (tailReg),
      .hit        (QueryHit1),
      .data       (QueryData1)
   );

   wb_fwd_lookup #(
      .DEPTH  (DEPTH),
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) uLookup2 (
      .queryReg   (QueryReg2),
      .entryReg   (regMem),
      .entryData  (dataMem),
      .entryValid (validReg),
      .tailPtr    (tailReg),
      .hit        (QueryHit2),
      .data       (QueryData2)
   );

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
// Table-driven bench for writeback_queue. Each vector drives one cycle of
// inputs; a queue model holds the results expected to reach the register
// file, in acceptance order, and every cycle's outputs are compared against
// it. Table records add hand-derived occupancy / ready / forwarding values.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

   localparam int DEPTH  = 4;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   logic              Clock;
   logic              Reset_n;
   logic              AluValid;
   logic [REG_AW-1:0] AluReg;
   logic [XLEN-1:0]   AluData;
   logic              AluReady;
   logic              MemValid;
   logic [REG_AW-1:0] MemReg;
   logic [XLEN-1:0]   MemData;
   logic              MemReady;
   logic              RegWrite;
   logic [REG_AW-1:0] WriteReg;
   logic [XLEN-1:0]   WriteData;
   logic [REG_AW-1:0] QueryReg1;
   logic [REG_AW-1:0] QueryReg2;
   logic              QueryHit1;
   logic [XLEN-1:0]   QueryData1;
   logic              QueryHit2;
   logic [XLEN-1:0]   QueryData2;
   logic [2:0]        Count;

   writeback_queue #(
      .DEPTH  (DEPTH),
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .AluValid   (AluValid),
      .AluReg     (AluReg),
      .AluData    (AluData),
      .AluReady   (AluReady),
      .MemValid   (MemValid),
      .MemReg     (MemReg),
      .MemData    (MemData),
      .MemReady   (MemReady),
      .RegWrite   (RegWrite),
      .WriteReg   (WriteReg),
      .WriteData  (WriteData),
      .QueryReg1  (QueryReg1),
      .QueryReg2  (QueryReg2),
      .QueryHit1  (QueryHit1),
      .QueryData1 (QueryData1),
      .QueryHit2  (QueryHit2),
      .QueryData2 (QueryData2),
      .Count      (Count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   typedef struct {
      bit          rstN;
      bit          mV;
      logic [4:0]  mR;
      logic [63:0] mD;
      bit          aV;
      logic [4:0]  aR;
      logic [63:0] aD;
      logic [4:0]  q1;
      logic [4:0]  q2;
      int          expCount;   // -1: not checked
      int          expAluRdy;  // -1: not checked
      int          expHit1;    // -1: not checked
      logic [63:0] expData1;   // checked together with expHit1
   } vec_t;

   typedef struct {
      logic [4:0]  r;
      logic [63:0] d;
   } ent_t;

   vec_t vecs[$];
   ent_t model[$];
   int   nVec;
   int   nComp;
   int   nFail;

   function automatic vec_t mk(input bit rstN, input bit mV, input logic [4:0] mR,
                               input logic [63:0] mD, input bit aV, input logic [4:0] aR,
                               input logic [63:0] aD, input logic [4:0] q1, input logic [4:0] q2,
                               input int expCount, input int expAluRdy, input int expHit1,
                               input logic [63:0] expData1);
      vec_t v;
      v.rstN = rstN; v.mV = mV; v.mR = mR; v.mD = mD;
      v.aV = aV; v.aR = aR; v.aD = aD; v.q1 = q1; v.q2 = q2;
      v.expCount = expCount; v.expAluRdy = expAluRdy;
      v.expHit1 = expHit1; v.expData1 = expData1;
      return v;
   endfunction

   function automatic vec_t idle(input logic [4:0] q1, input int expCount,
                                 input int expHit1, input logic [63:0] expData1);
      return mk(1, 0, 0, 0, 0, 0, 0, q1, 0, expCount, -1, expHit1, expData1);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      nComp++;
      if (act !== want) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (vector %0d)", name, act, want, nVec);
      end
   endtask

   // Youngest queued value for a register, from the model.
   task automatic modelLookup(input logic [4:0] q, output bit hit, output logic [63:0] d);
      hit = 1'b0;
      d   = '0;
      if (q != 0) begin
         for (int i = model.size() - 1; i >= 0; i--) begin
            if (model[i].r == q) begin
               hit = 1'b1;
               d   = model[i].d;
               break;
            end
         end
      end
   endtask

   task automatic applyCycle(input vec_t v);
      int          n;
      int          freeM;
      bit          memNeeds, aluNeeds, memRdy, aluRdy;
      bit          h1, h2;
      logic [63:0] d1, d2;
      ent_t        e;

      Reset_n   = v.rstN;
      MemValid  = v.mV;
      MemReg    = v.mR;
      MemData   = v.mD;
      AluValid  = v.aV;
      AluReg    = v.aR;
      AluData   = v.aD;
      QueryReg1 = v.q1;
      QueryReg2 = v.q2;
      #2;

      n        = model.size();
      freeM    = DEPTH - n + ((n != 0) ? 1 : 0);
      memNeeds = (v.mR != 0);
      aluNeeds = (v.aR != 0);
      memRdy   = (freeM >= 1) || !memNeeds;
      aluRdy   = !aluNeeds || (freeM >= 2) || ((freeM >= 1) && !(v.mV && memNeeds));
      modelLookup(v.q1, h1, d1);
      modelLookup(v.q2, h2, d2);

      check("Count", 64'(Count), 64'(n));
      check("RegWrite", 64'(RegWrite), 64'(n != 0));
      if (n != 0) begin
         check("WriteReg", 64'(WriteReg), 64'(model[0].r));
         check("WriteData", WriteData, model[0].d);
      end else begin
         check("WriteReg.empty", 64'(WriteReg), 64'(0));
         check("WriteData.empty", WriteData, 64'(0));
      end
      check("MemReady", 64'(MemReady), 64'(memRdy));
      check("AluReady", 64'(AluReady), 64'(aluRdy));
      check("QueryHit1", 64'(QueryHit1), 64'(h1));
      check("QueryData1", QueryData1, d1);
      check("QueryHit2", 64'(QueryHit2), 64'(h2));
      check("QueryData2", QueryData2, d2);

      if (v.expCount >= 0)  check("tbl.Count", 64'(Count), 64'(v.expCount));
      if (v.expAluRdy >= 0) check("tbl.AluReady", 64'(AluReady), 64'(v.expAluRdy));
      if (v.expHit1 >= 0) begin
         check("tbl.QueryHit1", 64'(QueryHit1), 64'(v.expHit1));
         check("tbl.QueryData1", QueryData1, v.expData1);
      end
      nVec++;

      @(posedge Clock);
      if (!v.rstN) begin
         model.delete();
      end else begin
         if (n != 0) void'(model.pop_front());
         if (v.mV && memRdy && memNeeds) begin
            e.r = v.mR; e.d = v.mD;
            model.push_back(e);
         end
         if (v.aV && aluRdy && aluNeeds) begin
            e.r = v.aR; e.d = v.aD;
            model.push_back(e);
         end
      end
      @(negedge Clock);
   endtask

   initial begin
      nVec = 0; nComp = 0; nFail = 0;
      Reset_n = 1'b0;
      MemValid = 1'b0; MemReg = '0; MemData = '0;
      AluValid = 1'b0; AluReg = '0; AluData = '0;
      QueryReg1 = '0; QueryReg2 = '0;

      // Single push, then drain
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 5, 105, 5, 0, 0, 1, 0, 0));
      vecs.push_back(idle(5, 1, 1, 105));
      vecs.push_back(idle(0, 0, -1, 0));
      // Dual push: load x6 written before ALU x7
      vecs.push_back(mk(1, 1, 6, 7, 1, 7, 9, 0, 0, 0, 1, -1, 0));
      vecs.push_back(idle(7, 2, 1, 9));
      vecs.push_back(idle(0, 1, -1, 0));
      vecs.push_back(idle(0, 0, -1, 0));
      // Backpressure: both producers valid for 8 cycles from empty
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(1, 1, 5'(8 + i), 64'(100 + i), 1, 5'(16 + i), 64'(200 + i), 0, 0,
                           (i == 0) ? 0 : (i == 1) ? 2 : (i == 2) ? 3 : 4,
                           (i < 3) ? 1 : 0, -1, 0));
      end
      // x0 ALU result while full: accepted, not enqueued
      vecs.push_back(mk(1, 1, 20, 1, 1, 0, 64'hFFFF, 0, 0, 4, 1, -1, 0));
      vecs.push_back(idle(0, 4, -1, 0));
      vecs.push_back(idle(0, 3, -1, 0));
      vecs.push_back(idle(0, 2, -1, 0));
      vecs.push_back(idle(0, 1, -1, 0));
      // Forwarding: two x3 entries, younger one wins
      vecs.push_back(mk(1, 1, 3, 10, 1, 3, 20, 3, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3, 4, 2, -1, 1, 20));
      vecs.push_back(idle(3, 1, 1, 20));
      // Reset mid-operation with both producers valid
      vecs.push_back(mk(1, 1, 9, 1, 1, 10, 2, 0, 0, 0, 1, -1, 0));
      vecs.push_back(mk(1, 1, 11, 3, 1, 12, 4, 0, 0, 2, 1, -1, 0));
      vecs.push_back(mk(0, 1, 13, 5, 1, 14, 6, 12, 0, 3, 1, 1, 4));
      vecs.push_back(mk(1, 0, 0, 0, 1, 15, 77, 10, 0, 0, 1, 0, 0));
      vecs.push_back(idle(15, 1, 1, 77));
      vecs.push_back(idle(0, 0, -1, 0));

      repeat (2) @(posedge Clock);
      @(negedge Clock);

      // Reset state
      check("rst.Count", 64'(Count), 64'(0));
      check("rst.RegWrite", 64'(RegWrite), 64'(0));
      check("rst.WriteReg", 64'(WriteReg), 64'(0));
      check("rst.WriteData", WriteData, 64'(0));
      check("rst.QueryHit1", 64'(QueryHit1), 64'(0));
      check("rst.QueryHit2", 64'(QueryHit2), 64'(0));

      foreach (vecs[i]) applyCycle(vecs[i]);

      // Mixed traffic over a small register range so lookups hit and the
      // pointers wrap many times; the model alone supplies expectations.
      for (int i = 0; i < 60; i++) begin
         applyCycle(mk(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       {$urandom, $urandom},
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       {$urandom, $urandom},
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       -1, -1, -1, 0));
      end
      // Drain what is left
      for (int i = 0; i < DEPTH + 1; i++) applyCycle(idle(0, -1, -1, 0));
      check("end.Count", 64'(Count), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writeback stage directly upstream of RegisterFile; owns its single write port (RegWrite/WriteReg/WriteData).
- Collects results from two producers, the ALU and the load unit. Both can complete in the same cycle.
- Buffers results in a small in-order queue and drains exactly one entry per cycle into the register file.
- Provides a two-port forwarding lookup so decode can read values still queued and not yet written.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- XLEN, 64, data width; matches RegisterFile.
- REG_AW, 5, register address width (32 registers, x0 hardwired zero).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  synchronous active-low reset.
- AluValid  in  1  ALU result valid.
- AluReg  in  REG_AW  ALU destination register.
- AluData  in  XLEN  ALU result.
- AluReady  out  1  ALU result accepted this cycle.
- MemValid  in  1  load result valid.
- MemReg  in  REG_AW  load destination register.
- MemData  in  XLEN  load data.
- MemReady  out  1  load result accepted this cycle.
- RegWrite  out  1  write enable to RegisterFile.
- WriteReg  out  REG_AW  write address to RegisterFile.
- WriteData  out  XLEN  write data to RegisterFile.
- QueryReg1  in  REG_AW  forwarding lookup address 1.
- QueryReg2  in  REG_AW  forwarding lookup address 2.
- QueryHit1  out  1  QueryReg1 pending in queue.
- QueryData1  out  XLEN  youngest queued value for QueryReg1.
- QueryHit2  out  1  QueryReg2 pending in queue.
- QueryData2  out  XLEN  youngest queued value for QueryReg2.
- Count  out  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (Reset_n=0 at a rising edge):
  - Count=0; head and tail pointers = 0; all entry valids cleared.
  - Outputs: RegWrite=0, WriteReg=0, WriteData=0, QueryHit*=0, QueryData*=0.
  - Reset wins over any simultaneous push or pop. Entries in flight are discarded.
- Drain:
  - RegWrite = (Count != 0), combinational from state.
  - WriteReg/WriteData = head entry; forced to 0 when empty.
  - The register file always accepts the write, so the head pops on every edge where Count != 0.
  - Pushed-to-write latency is 1 cycle minimum: an entry pushed at edge N appears on the outputs after edge N and is written at edge N+1.
- Capacity:
  - free = DEPTH - Count + (Count != 0); the slot popped this edge counts as free.
  - A producer whose destination register is 0 needs no slot.
- Push rules:
  - A handshake completes when Valid & Ready are both high at a rising edge.
  - MemReady = (free >= 1) or (MemReg == 0).
  - AluReady = (AluReg == 0) or (free >= 2) or (free >= 1 and not (MemValid and MemReg != 0)).
  - Ready never depends on the producer's own Valid.
  - AluReady may depend combinationally on MemValid/MemReg. No other combinational input-to-output paths exist, except the Query lookups.
- Ordering:
  - On a same-cycle double push, the load entry is older and is enqueued first; the ALU entry is enqueued behind it.
  - If only one slot is free, the load takes it and the ALU is stalled.
- x0 filtering: an accepted handshake with destination 0 is dropped, never enqueued, and has no effect on Count.
- Full/empty boundaries:
  - Count == DEPTH: still pops one entry this edge, so free = 1 and one push is allowed.
  - Count == 0: no pop, so free = DEPTH.
  - Pointers wrap modulo DEPTH.
  - Count changes by (pushes - pop) in the range -1..+2 and never exceeds DEPTH.
- Forwarding:
  - The lookup is combinational over currently queued valid entries, including the head being written this cycle.
  - Same-cycle inputs are excluded; the producer bypasses those itself.
  - Hit = any valid entry whose register matches. Data = the youngest matching entry, searched from tail-1 toward head.
  - Query address 0 always gives Hit=0, Data=0.

Decomposition:
- Shared package `wb_pkg`:
  - XLEN, REG_AW, and DEPTH default.
  - Entry struct {reg addr, data}.
  - Function computing free slots.
- One natural sub-module, `wb_fwd_lookup`: a youngest-match priority search over the entry array. It is instantiated twice, once per query port.

Test Plan:
- Single push: reset, then ALU push (x5, 105) -> RegWrite=1, WriteReg=5, WriteData=105 in the next cycle; Count returns to 0 after one more edge; RegisterFile x5 reads 105.
- Dual push: same cycle Mem (x6, 7) and ALU (x7, 9) -> writes occur x6 then x7 on consecutive cycles; Count peaks at 2.
- Backpressure: hold both producers valid (distinct non-zero registers) for 8 cycles from empty -> Count saturates at DEPTH=4. At steady state MemReady=1 and AluReady=0 every cycle. No entry lost or duplicated; drain order matches acceptance order.
- x0 filter: ALU push (x0, 0xFFFF) with Count=DEPTH -> AluReady=1; Count unchanged; RegWrite never issues WriteReg=0.
- Forwarding: queue holds x3=10 (older) and x3=20 (younger); QueryReg1=3 -> QueryHit1=1, QueryData1=20. QueryReg2=4 -> QueryHit2=0.
- Reset mid-operation: Count=3, then Reset_n=0 for one edge with both producers valid -> Count=0, RegWrite=0, QueryHit*=0. A push the following cycle is written normally.
